// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: op and error encodings,
// FSM states, access-size helpers and the default data-space limit.
package lsu_pkg;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_3000;
    localparam int          TIMEOUT_DEFAULT    = 16;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Access width implied by an op code.
    function automatic lsu_size_e op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    // Stores occupy the top three encodings.
    function automatic logic op_is_store(input logic [2:0] op);
        return (op >= OP_SB);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables and store replication for the outgoing
// word, plus extraction and sign/zero extension of returned load data.
// Purely combinational so the cache path can reuse it.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign rdata_sh = rdata >> {addr_lo, 3'b000};
    assign byte_val = rdata_sh[7:0];
    assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Byte enables and lane-replicated store data by access size.
    always_comb begin
        byteen    = 4'b1111;
        wdata_rep = wdata;
        case (op_size(op))
            SZ_B: begin
                byteen    = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                byteen    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                byteen    = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load data extraction with sign or zero extension; stores return 0.
    always_comb begin
        rdata_ext = 32'd0;
        case (op)
            OP_LB:   rdata_ext = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  rdata_ext = {24'd0, byte_val};
            OP_LH:   rdata_ext = {{16{half_val[15]}}, half_val};
            OP_LHU:  rdata_ext = {16'd0, half_val};
            OP_LW:   rdata_ext = rdata;
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: accepts one core request at a time, rejects
// misaligned or out-of-range accesses without touching the bus, otherwise
// runs one word-aligned bus cycle with a bounded wait for acknowledge and
// returns a single-cycle response.
module lsu_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT,
    parameter int          TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter value during the last permitted wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_reg;
    logic [2:0]  op_reg;
    logic [1:0]  addr_lo_reg;
    logic [7:0]  cnt_reg;
    lsu_err_e    req_err;

    logic [2:0]  lane_op;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_byteen;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // In IDLE the lane sees the incoming request so bus fields can be
    // registered on the accept edge; afterwards it sees the latched request
    // for load extraction.
    assign lane_op      = (state_reg == ST_IDLE) ? req_op : op_reg;
    assign lane_addr_lo = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_lo_reg;

    lsu_lane u_lane (
        .op        (lane_op),
        .addr_lo   (lane_addr_lo),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .byteen    (lane_byteen),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Request legality; misalignment takes precedence over range.
    always_comb begin
        req_err = ERR_OK;
        if ((op_size(req_op) == SZ_H && req_addr[0]) ||
            (op_size(req_op) == SZ_W && req_addr[1:0] != 2'b00)) begin
            req_err = ERR_MISALIGN;
        end else if (req_addr >= ADDR_LIMIT) begin
            req_err = ERR_RANGE;
        end
    end

    // Control FSM with request latch, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            op_reg      <= 3'd0;
            addr_lo_reg <= 2'd0;
            cnt_reg     <= 8'd0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 2'd0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_byteen  <= 4'd0;
            bus_wdata   <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        op_reg      <= req_op;
                        addr_lo_reg <= req_addr[1:0];
                        req_ready   <= 1'b0;
                        if (req_err != ERR_OK) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state_reg  <= ST_ISSUE;
                            cnt_reg    <= 8'd0;
                            bus_req    <= 1'b1;
                            bus_we     <= op_is_store(req_op);
                            bus_addr   <= {req_addr[31:2], 2'b00};
                            bus_byteen <= lane_byteen;
                            bus_wdata  <= lane_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    // An ack in the final wait cycle still counts as success.
                    if (bus_ack || cnt_reg == CNT_LAST) begin
                        state_reg  <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= 32'd0;
                        bus_byteen <= 4'd0;
                        bus_wdata  <= 32'd0;
                        if (bus_ack) begin
                            rsp_err   <= ERR_OK;
                            rsp_rdata <= lane_rdata;
                        end else begin
                            rsp_err   <= ERR_TIMEOUT;
                            rsp_rdata <= 32'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 2'd0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: a driver issues requests and plays the
// memory, pushing each expected response into a scoreboard queue; an
// independent monitor pops and compares whenever rsp_valid is seen.
module tb_lsu_master;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } rsp_t;
    rsp_t sb_q[$];

    lsu_master #(.ADDR_LIMIT(32'h0000_3000), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1) begin
            rsp_t e;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One request: drive it, act as memory (ack in ISSUE cycle ack_at, 0 = never),
    // check bus fields every ISSUE cycle and the bus_req duration.
    task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at, input logic [31:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        int   n_req = 0;
        int   exp_cycles;
        bit   seen = 1'b0;
        rsp_t e;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        check({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        exp_cycles = (exp_err == 2'd1 || exp_err == 2'd2) ? 0 : ((ack_at == 0) ? TO : ack_at);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + exp_cycles;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (bus_req === 1'b1) begin
                n_req++;
                check({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
                check({tag, "_bus_byteen"}, {28'd0, bus_byteen}, {28'd0, exp_be});
                check({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, (op >= 3'd5)});
                if (op >= 3'd5) check({tag, "_bus_wdata"}, bus_wdata, exp_wd);
                bus_ack   = (n_req == ack_at);
                bus_rdata = rd;
            end else begin
                bus_ack = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        bus_ack = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_no_rsp: got no rsp_valid within 40 cycles expected one", tag);
        end
        check({tag, "_bus_req_cycles"}, 32'(n_req), 32'(exp_cycles));
        @(negedge clk);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_bus_req_idle"}, {31'd0, bus_req}, 32'd0);
        $display("xact %s op=%0d addr=%08h bus_cycles=%0d exp_rdata=%08h exp_err=%0d",
                 tag, op, addr, n_req, exp_rdata, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_bus_byteen", {28'd0, bus_byteen}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        //   tag     op      addr           wdata          ack rd             be       wd             rdata          err
        xact("sw",   OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 2,  32'hFFFF_FFFF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0);
        xact("sb",   OP_SB,  32'h0000_0013, 32'h0000_00AB, 1,  32'hFFFF_FFFF, 4'b1000, 32'hABAB_ABAB, 32'h0000_0000, 2'd0);
        xact("lb",   OP_LB,  32'h0000_0012, 32'h0,         1,  32'h0080_FF00, 4'b0100, 32'h0,         32'hFFFF_FF80, 2'd0);
        xact("lbu",  OP_LBU, 32'h0000_0012, 32'h0,         3,  32'h0080_FF00, 4'b0100, 32'h0,         32'h0000_0080, 2'd0);
        xact("lh",   OP_LH,  32'h0000_0022, 32'h0,         1,  32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001, 2'd0);
        xact("lhu",  OP_LHU, 32'h0000_001E, 32'h0,         2,  32'hBEEF_0000, 4'b1100, 32'h0,         32'h0000_BEEF, 2'd0);
        xact("sh",   OP_SH,  32'h0000_001A, 32'h1234_CAFE, 1,  32'hFFFF_FFFF, 4'b1100, 32'hCAFE_CAFE, 32'h0000_0000, 2'd0);
        xact("mis",  OP_LW,  32'h0000_0006, 32'h0,         1,  32'h0,         4'b1111, 32'h0,         32'h0000_0000, 2'd1);
        xact("misb", OP_LH,  32'h0000_0005, 32'h0,         1,  32'h0,         4'b0011, 32'h0,         32'h0000_0000, 2'd1);
        xact("rng",  OP_LW,  32'h0000_3000, 32'h0,         1,  32'h0,         4'b1111, 32'h0,         32'h0000_0000, 2'd2);
        xact("prec", OP_LW,  32'h0000_3002, 32'h0,         1,  32'h0,         4'b1111, 32'h0,         32'h0000_0000, 2'd1);
        xact("top",  OP_LW,  32'h0000_2FFC, 32'h0,         1,  32'h1234_5678, 4'b1111, 32'h0,         32'h1234_5678, 2'd0);
        xact("tmo",  OP_LW,  32'h0000_0040, 32'h0,         0,  32'hFFFF_FFFF, 4'b1111, 32'h0,         32'h0000_0000, 2'd3);
        xact("last", OP_LW,  32'h0000_0044, 32'h0,         TO, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D, 2'd0);

        // Reset pulled low in the middle of a bus cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h0000_0050;
        req_wdata = 32'h0000_0001;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_bus_req_before", {31'd0, bus_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_bus_req_async", {31'd0, bus_req}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (TO + 4) @(negedge clk);
        check("rst_mid_bus_req_idle", {31'd0, bus_req}, 32'd0);
        $display("xact rst_mid op=%0d addr=%08h aborted by reset", OP_SW, 32'h0000_0050);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
